// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants and the multdiv sequencer state type for the
// 5-stage pipelined CPU control blocks.
package cpu_isa_pkg;

  // Opcode field encodings (instruction bits [31:27]).
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  // ALU-op field encodings that route to the multiplier/divider.
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // Status register read implicitly by bex.
  localparam logic [4:0] REG_STATUS = 5'd30;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_t;

  // True when the opcode/aluop pair names a mul or div.
  function automatic logic is_multdiv(input logic [4:0] opcode,
                                      input logic [4:0] aluop);
    return (opcode == OP_RTYPE) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
  endfunction

endpackage

// File: rtl/src_reg_decode.sv
// Source-register usage decode for the instruction in the F/D latch.
// Reports which register fields are actually read; register 0 filtering
// is left to the consumer (hazard or forwarding logic).
module src_reg_decode
  import cpu_isa_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output logic       uses_a,
  output logic       uses_b,
  output logic [4:0] reg_a,
  output logic [4:0] reg_b
);

  // Map each opcode to the register fields it reads.
  always_comb begin
    uses_a = 1'b0;
    uses_b = 1'b0;
    reg_a  = '0;
    reg_b  = '0;
    case (opcode)
      OP_RTYPE: begin
        uses_a = 1'b1; reg_a = rs;
        uses_b = 1'b1; reg_b = rt;
      end
      OP_ADDI, OP_LW: begin
        uses_a = 1'b1; reg_a = rs;
      end
      OP_SW: begin
        uses_a = 1'b1; reg_a = rs;
        uses_b = 1'b1; reg_b = rd;
      end
      OP_BNE, OP_BLT: begin
        uses_a = 1'b1; reg_a = rd;
        uses_b = 1'b1; reg_b = rs;
      end
      OP_JR: begin
        uses_a = 1'b1; reg_a = rd;
      end
      OP_BEX: begin
        uses_a = 1'b1; reg_a = REG_STATUS;
      end
      default: begin
        uses_a = 1'b0;
        uses_b = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller: load-use stall, taken-branch flush and
// the multdiv start/wait/writeback sequence for the 5-stage pipeline.
module pipeline_hazard_ctrl
  import cpu_isa_pkg::*;
#(
  parameter int unsigned MD_MAX_CYCLES = 40,
  parameter int unsigned CNT_W         = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] fd_opcode,
  input  logic [4:0] fd_rs,
  input  logic [4:0] fd_rt,
  input  logic [4:0] fd_rd,
  input  logic [4:0] dx_opcode,
  input  logic [4:0] dx_aluop,
  input  logic [4:0] dx_rd,
  input  logic       branch_taken,
  input  logic       md_ready,
  output logic       stall_fd,
  output logic       stall_dx,
  output logic       bubble_xm,
  output logic       bubble_dx,
  output logic       flush_fd,
  output logic       md_ctrl_mult,
  output logic       md_ctrl_div,
  output logic       md_wb_sel,
  output logic       md_timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_MAX_CYCLES - 1);

  logic       uses_a;
  logic       uses_b;
  logic [4:0] reg_a;
  logic [4:0] reg_b;

  src_reg_decode u_src_reg_decode (
    .opcode (fd_opcode),
    .rs     (fd_rs),
    .rt     (fd_rt),
    .rd     (fd_rd),
    .uses_a (uses_a),
    .uses_b (uses_b),
    .reg_a  (reg_a),
    .reg_b  (reg_b)
  );

  logic dx_is_lw;
  logic dx_is_md;
  logic load_use;

  // Load-use detection; a nonzero dx_rd match also excludes r0 on the F/D side.
  always_comb begin
    dx_is_lw = (dx_opcode == OP_LW);
    dx_is_md = is_multdiv(dx_opcode, dx_aluop);
    load_use = dx_is_lw && (dx_rd != '0) &&
               ((uses_a && (reg_a == dx_rd)) || (uses_b && (reg_b == dx_rd)));
  end

  md_state_t        state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             timeout_q, timeout_d;
  logic             mult_q,    mult_d;
  logic             div_q,     div_d;
  logic             md_stall;

  // Multdiv sequencer next-state: start pulse registered into the first BUSY cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    mult_d    = 1'b0;
    div_d     = 1'b0;
    md_stall  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        cnt_d     = '0;
        timeout_d = 1'b0;
        if (dx_is_md) begin
          md_stall = 1'b1;
          state_d  = MD_BUSY;
          mult_d   = (dx_aluop == ALU_MUL);
          div_d    = (dx_aluop == ALU_DIV);
        end
      end
      MD_BUSY: begin
        md_stall = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (md_ready) begin
          state_d = MD_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = MD_DONE;
          timeout_d = 1'b1;
        end
      end
      MD_DONE: begin
        state_d   = MD_IDLE;
        cnt_d     = '0;
        timeout_d = 1'b0;
      end
      default: begin
        state_d   = MD_IDLE;
        cnt_d     = '0;
        timeout_d = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered start pulses, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      mult_q    <= 1'b0;
      div_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      mult_q    <= mult_d;
      div_q     <= div_d;
    end
  end

  // Output merge; flush overrides the load-use stall, and reset silences everything.
  always_comb begin
    stall_fd     = 1'b0;
    stall_dx     = 1'b0;
    bubble_xm    = 1'b0;
    bubble_dx    = 1'b0;
    flush_fd     = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    md_wb_sel    = 1'b0;
    md_timeout   = 1'b0;
    if (!reset) begin
      stall_fd     = md_stall || (load_use && !branch_taken);
      stall_dx     = md_stall;
      bubble_xm    = md_stall;
      bubble_dx    = load_use || branch_taken;
      flush_fd     = branch_taken;
      md_ctrl_mult = mult_q;
      md_ctrl_div  = div_q;
      md_wb_sel    = (state_q == MD_DONE);
      md_timeout   = (state_q == MD_DONE) && timeout_q;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios followed
// by randomized traffic, checked cycle by cycle against a transaction model.
module tb_pipeline_hazard_ctrl;
  import cpu_isa_pkg::*;

  localparam int unsigned MAXC = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] fd_opcode = '0, fd_rs = '0, fd_rt = '0, fd_rd = '0;
  logic [4:0] dx_opcode = '0, dx_aluop = '0, dx_rd = '0;
  logic       branch_taken = 1'b0, md_ready = 1'b0;
  logic       stall_fd, stall_dx, bubble_xm, bubble_dx, flush_fd;
  logic       md_ctrl_mult, md_ctrl_div, md_wb_sel, md_timeout;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.MD_MAX_CYCLES(MAXC), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .fd_opcode(fd_opcode), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_rd(fd_rd),
    .dx_opcode(dx_opcode), .dx_aluop(dx_aluop), .dx_rd(dx_rd),
    .branch_taken(branch_taken), .md_ready(md_ready),
    .stall_fd(stall_fd), .stall_dx(stall_dx), .bubble_xm(bubble_xm),
    .bubble_dx(bubble_dx), .flush_fd(flush_fd),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_wb_sel(md_wb_sel), .md_timeout(md_timeout)
  );

  typedef struct packed {
    logic stall_fd, stall_dx, bubble_xm, bubble_dx, flush_fd;
    logic mult, div, wb, to;
  } out_t;

  typedef struct {
    out_t  e;
    string tag;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  string       phase    = "init";

  // Transaction model of the multdiv operation in flight.
  bit op_active  = 0;
  bit op_is_mul  = 0;
  bit op_to      = 0;
  int op_start   = 0;
  int op_done_at = -1;
  int cyc        = 0;

  // Does the F/D instruction read register r (r0 never counts)?
  function automatic bit fd_reads(input logic [4:0] op, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    case (op)
      OP_RTYPE:              return (r == rs) || (r == rt);
      OP_ADDI, OP_LW:        return (r == rs);
      OP_SW, OP_BNE, OP_BLT: return (r == rs) || (r == rd);
      OP_JR:                 return (r == rd);
      OP_BEX:                return (r == 5'd30);
      default:               return 1'b0;
    endcase
  endfunction

  // One clock of stimulus; D/X is held while the model has an op in flight.
  task automatic step(input bit rst,
                      input logic [4:0] f_op, input logic [4:0] f_rs,
                      input logic [4:0] f_rt, input logic [4:0] f_rd,
                      input logic [4:0] d_op, input logic [4:0] d_alu,
                      input logic [4:0] d_rd, input bit br, input bit rdy);
    out_t e;
    bit   md_in;
    exp_t x;
    @(posedge clock);
    #1;
    reset     = rst;
    fd_opcode = f_op; fd_rs = f_rs; fd_rt = f_rt; fd_rd = f_rd;
    if (!op_active) begin
      dx_opcode = d_op; dx_aluop = d_alu; dx_rd = d_rd;
    end
    md_in        = (dx_opcode == OP_RTYPE) && (dx_aluop == ALU_MUL || dx_aluop == ALU_DIV);
    branch_taken = br && !md_in;
    md_ready     = rdy;
    e = '0;
    if (rst) begin
      op_active = 0;
    end else begin
      if (!op_active && md_in) begin
        op_active  = 1;
        op_is_mul  = (dx_aluop == ALU_MUL);
        op_start   = cyc;
        op_done_at = -1;
        op_to      = 0;
      end
      if (op_active) begin
        if (cyc == op_done_at) begin
          e.wb = 1'b1;
          e.to = op_to;
          op_active = 0;
        end else begin
          e.stall_fd = 1'b1; e.stall_dx = 1'b1; e.bubble_xm = 1'b1;
          if (cyc == op_start + 1) begin
            e.mult = op_is_mul;
            e.div  = !op_is_mul;
          end
          if (cyc > op_start && op_done_at < 0) begin
            if (rdy) begin
              op_done_at = cyc + 1;
            end else if (cyc == op_start + int'(MAXC)) begin
              op_done_at = cyc + 1;
              op_to      = 1;
            end
          end
        end
      end else begin
        if (branch_taken) begin
          e.flush_fd  = 1'b1;
          e.bubble_dx = 1'b1;
        end else if (dx_opcode == OP_LW && fd_reads(fd_opcode, fd_rs, fd_rt, fd_rd, dx_rd)) begin
          e.stall_fd  = 1'b1;
          e.bubble_dx = 1'b1;
        end
      end
    end
    x.e   = e;
    x.tag = phase;
    exp_q.push_back(x);
    cyc++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++)
      step(0, OP_J, 5'd0, 5'd0, 5'd0, OP_RTYPE, 5'd0, 5'd0, 0, rdy);
  endtask

  task automatic md_op(input logic [4:0] alu, input bit rst, input bit rdy);
    step(rst, OP_J, 5'd0, 5'd0, 5'd0, OP_RTYPE, alu, 5'd4, 0, rdy);
  endtask

  // Monitor: compare every presented output vector against the queue head.
  always @(negedge clock) begin
    exp_t x;
    out_t a;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      a = {stall_fd, stall_dx, bubble_xm, bubble_dx, flush_fd,
           md_ctrl_mult, md_ctrl_div, md_wb_sel, md_timeout};
      n_checks++;
      if (a === x.e) n_pass++;
      else $display("FAIL %s @%0t: outputs got %b required %b (sfd,sdx,bxm,bdx,ffd,mul,div,wb,to)",
                    x.tag, $time, a, x.e);
      assert (!(branch_taken && dx_opcode == OP_RTYPE &&
                (dx_aluop == ALU_MUL || dx_aluop == ALU_DIV)));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  logic [4:0] ops [12] = '{OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT,
                           OP_JR, OP_BEX, OP_J, OP_JAL, OP_SETX, 5'b11111};

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(9) == 0) return 5'd30;
    return 5'($urandom_range(7));
  endfunction

  initial begin
    logic [4:0] fo, dop, dal;
    int unsigned k;

    phase = "reset";
    step(1, OP_RTYPE, 5'd5, 5'd2, 5'd1, OP_LW, 5'd0, 5'd5, 1, 1);
    step(1, OP_J, 5'd0, 5'd0, 5'd0, OP_RTYPE, 5'd0, 5'd0, 0, 0);
    idle(2, 0);

    phase = "load_use_add";
    step(0, OP_RTYPE, 5'd5, 5'd2, 5'd1, OP_LW, 5'd0, 5'd5, 0, 0);
    step(0, OP_RTYPE, 5'd5, 5'd2, 5'd1, OP_RTYPE, 5'd0, 5'd0, 0, 0);
    phase = "load_use_r0";
    step(0, OP_RTYPE, 5'd0, 5'd2, 5'd1, OP_LW, 5'd0, 5'd0, 0, 0);
    phase = "load_use_sw_rd";
    step(0, OP_SW, 5'd3, 5'd0, 5'd7, OP_LW, 5'd0, 5'd7, 0, 0);
    phase = "load_use_bex";
    step(0, OP_BEX, 5'd0, 5'd0, 5'd0, OP_LW, 5'd0, 5'd30, 0, 0);
    phase = "no_use_jal";
    step(0, OP_JAL, 5'd5, 5'd5, 5'd5, OP_LW, 5'd0, 5'd5, 0, 0);
    phase = "flush_over_load_use";
    step(0, OP_BNE, 5'd3, 5'd0, 5'd5, OP_LW, 5'd0, 5'd5, 1, 0);
    idle(1, 0);

    phase = "mul_ready_7";
    for (int i = 0; i < 9; i++) md_op(ALU_MUL, 0, i == 7);
    idle(2, 0);

    phase = "div_timeout";
    for (int i = 0; i < int'(MAXC) + 2; i++) md_op(ALU_DIV, 0, 0);
    idle(2, 0);

    phase = "reset_mid_busy";
    for (int i = 0; i < 4; i++) md_op(ALU_MUL, i == 3, 0);
    idle(1, 0);
    idle(1, 1);
    idle(2, 0);

    phase = "back_to_back_mul";
    for (int i = 0; i < 8; i++) md_op(ALU_MUL, 0, 1);
    idle(2, 0);

    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      fo = ops[$urandom_range(11)];
      k  = $urandom_range(9);
      if (k < 4) begin
        dop = OP_LW; dal = 5'($urandom_range(31));
      end else if (k == 4) begin
        dop = OP_RTYPE; dal = ALU_MUL;
      end else if (k == 5) begin
        dop = OP_RTYPE; dal = ALU_DIV;
      end else begin
        dop = ops[$urandom_range(11)]; dal = 5'($urandom_range(5));
      end
      step($urandom_range(79) == 0, fo, rnd_reg(), rnd_reg(), rnd_reg(),
           dop, dal, rnd_reg(), $urandom_range(6) == 0, $urandom_range(4) == 0);
    end

    phase = "drain";
    repeat (3) @(posedge clock);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
